multi_channel_delay_ise: RTL



---
 rtl/multi_channel_delay_ise_if.sv | 13 +
 rtl/multi_channel_delay_ise.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_delay_ise_if.sv
// Custom-instruction bus between the CPU and the multi-channel delay unit.
interface multi_channel_delay_ise_if;
  logic        ciStart;
  logic        ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;

  modport master (output ciStart, ciCke, ciN, ciValueA, ciValueB, input ciDone, ciResult);
  modport slave  (input ciStart, ciCke, ciN, ciValueA, ciValueB, output ciDone, ciResult);
endinterface

// File: rtl/multi_channel_delay_ise.sv
// Multi-channel microsecond timer on the custom-instruction bus: blocking delay, one-shot
// and periodic channels sharing one prescaler, with pending flags and a maskable interrupt.
module multi_channel_delay_ise #(
  parameter int unsigned clockFrequencyInHz  = 48000000,
  parameter logic [7:0]  customInstructionId = 8'd0,
  parameter int unsigned nrOfChannels        = 4,
  parameter int unsigned counterWidth        = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  multi_channel_delay_ise_if.slave ci,
  output logic                     irq,
  output logic [nrOfChannels-1:0]  expired
);

  localparam int unsigned divider       = clockFrequencyInHz / 1000000;
  localparam int unsigned prescaleWidth = (divider > 1) ? $clog2(divider) : 1;
  localparam logic [prescaleWidth-1:0] prescaleReload = prescaleWidth'(divider - 1);

  typedef enum logic [2:0] {
    opBlock    = 3'd0,
    opStart    = 3'd1,
    opPeriodic = 3'd2,
    opRead     = 3'd3,
    opStop     = 3'd4,
    opStatus   = 3'd5,
    opAck      = 3'd6,
    opIrqMask  = 3'd7
  } opcodeT;

  typedef enum logic [1:0] {
    stIdle = 2'd0,
    stWait = 2'd1,
    stDone = 2'd2
  } fsmStateT;

  logic [prescaleWidth-1:0]                  prescaler;
  logic                                      tick;
  logic [nrOfChannels-1:0][counterWidth-1:0] count, countNext;
  logic [nrOfChannels-1:0][counterWidth-1:0] reloadValue, reloadNext;
  logic [nrOfChannels-1:0]                   periodic, periodicNext;
  logic [nrOfChannels-1:0]                   pending, pendingNext;
  logic [nrOfChannels-1:0]                   irqMask, irqMaskNext;
  logic [nrOfChannels-1:0]                   expireNow, running, chanSel;
  fsmStateT                                  state, stateNext;
  logic [3:0]                                waitChannel, waitChannelNext;
  logic                                      doneNext, waitExpire;
  logic [31:0]                               resultNext;

  opcodeT                  opcode;
  logic [3:0]              channel;
  logic                    channelValid, accept;
  logic [counterWidth-1:0] loadValue, selCount;
  logic [nrOfChannels-1:0] maskOperand;

  assign opcode       = opcodeT'(ci.ciValueB[2:0]);
  assign channel      = ci.ciValueB[7:4];
  assign channelValid = 32'(channel) < nrOfChannels;
  assign loadValue    = ci.ciValueA[counterWidth-1:0];
  assign maskOperand  = ci.ciValueA[nrOfChannels-1:0];
  // The CPU is stalled while a blocking delay runs, so only IDLE accepts instructions.
  assign accept = ci.ciStart && ci.ciCke && (ci.ciN == customInstructionId) && (state == stIdle);
  assign tick   = (prescaler == '0);

  // Free-running microsecond prescaler, never resynchronised by instructions.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prescaler <= prescaleReload;
    else        prescaler <= tick ? prescaleReload : prescaler - prescaleWidth'(1);
  end

  // Channel decode, selected-count mux and running flags.
  always_comb begin
    chanSel  = '0;
    selCount = '0;
    running  = '0;
    for (int unsigned i = 0; i < nrOfChannels; i++) begin
      chanSel[i] = (channel == 4'(i));
      running[i] = (count[i] != '0);
      if (chanSel[i]) selCount = count[i];
    end
  end

  // Per-channel countdown; an instruction on a channel overrides that channel's tick.
  always_comb begin
    countNext    = count;
    reloadNext   = reloadValue;
    periodicNext = periodic;
    pendingNext  = pending;
    irqMaskNext  = irqMask;
    expireNow    = '0;
    for (int unsigned i = 0; i < nrOfChannels; i++) begin
      if (tick && (count[i] != '0)) begin
        countNext[i] = count[i] - counterWidth'(1);
        if (count[i] == counterWidth'(1)) begin
          expireNow[i] = 1'b1;
          if (periodic[i]) countNext[i] = reloadValue[i];
        end
      end
      if (accept && chanSel[i]) begin
        case (opcode)
          opBlock, opStart: begin
            countNext[i]    = loadValue;
            periodicNext[i] = 1'b0;
            expireNow[i]    = 1'b0;
          end
          opPeriodic: begin
            countNext[i]    = loadValue;
            reloadNext[i]   = loadValue;
            periodicNext[i] = 1'b1;
            expireNow[i]    = 1'b0;
          end
          opStop: begin
            countNext[i]    = '0;
            periodicNext[i] = 1'b0;
            pendingNext[i]  = 1'b0;
            expireNow[i]    = 1'b0;
          end
          default: ;
        endcase
      end
    end
    if (accept && (opcode == opAck))     pendingNext = pending & ~maskOperand;
    if (accept && (opcode == opIrqMask)) irqMaskNext = maskOperand;
    // A new expiry beats a simultaneous acknowledge.
    pendingNext = pendingNext | expireNow;
  end

  always_comb begin
    waitExpire = 1'b0;
    for (int unsigned i = 0; i < nrOfChannels; i++) begin
      if (waitChannel == 4'(i)) waitExpire = expireNow[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= stIdle;
      waitChannel <= '0;
    end else begin
      state       <= stateNext;
      waitChannel <= waitChannelNext;
    end
  end

  // Instruction sequencing and result selection.
  always_comb begin
    stateNext       = state;
    waitChannelNext = waitChannel;
    doneNext        = 1'b0;
    resultNext      = '0;
    case (state)
      stIdle: begin
        if (accept) begin
          doneNext = 1'b1;
          case (opcode)
            opBlock: begin
              if (!channelValid) begin
                resultNext = '1;
              end else if (loadValue != '0) begin
                stateNext       = stWait;
                waitChannelNext = channel;
                doneNext        = 1'b0;
              end
            end
            opStart, opPeriodic, opRead, opStop: resultNext = channelValid ? 32'(selCount) : '1;
            opStatus:  resultNext = {16'(running), 16'(pending)};
            opAck:     resultNext = 32'(pending);
            opIrqMask: resultNext = 32'(irqMask);
            default: ;
          endcase
        end
      end
      stWait: begin
        if (waitExpire) begin
          stateNext = stDone;
          doneNext  = 1'b1;
        end
      end
      stDone:  stateNext = stIdle;
      default: stateNext = stIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      reloadValue <= '0;
      periodic    <= '0;
      pending     <= '0;
      irqMask     <= '0;
      expired     <= '0;
      irq         <= 1'b0;
      ci.ciDone   <= 1'b0;
      ci.ciResult <= '0;
    end else begin
      count       <= countNext;
      reloadValue <= reloadNext;
      periodic    <= periodicNext;
      pending     <= pendingNext;
      irqMask     <= irqMaskNext;
      expired     <= expireNow;
      irq         <= |(pending & irqMask);
      ci.ciDone   <= doneNext;
      ci.ciResult <= resultNext;
    end
  end

endmodule
